matrix_dp_collector: RTL and testbench

- Receiving end of the matrix_dp systolic datapath.
- matrix_dp's input feeder drives skewed x columns; its z0..z7 results emerge staggered, one lane per cycle.
- This block samples each lane at its own cycle, de-skews the lanes into a result vector and streams the vector out one 16-bit Q2.14 word per beat over a valid/ready interface.
- Two capture banks (ping-pong), so a new matrix_dp pass can be collected while the previous vector is still draining.

---
 rtl/matrix_dp_collector.sv | 105 ++++++++++
 tb/tb_matrix_dp_collector.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_dp_collector.sv
// matrix_dp_collector: de-skews staggered matrix_dp z lanes into ping-pong banks and streams each vector as valid/ready words
module matrix_dp_collector #(
    parameter int N       = 8,
    parameter int DW      = 16,
    parameter int CAP_OFS = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [3:0]    len,
    input  logic [DW-1:0] z0,
    input  logic [DW-1:0] z1,
    input  logic [DW-1:0] z2,
    input  logic [DW-1:0] z3,
    input  logic [DW-1:0] z4,
    input  logic [DW-1:0] z5,
    input  logic [DW-1:0] z6,
    input  logic [DW-1:0] z7,
    output logic [DW-1:0] m_tdata,
    output logic          m_tvalid,
    input  logic          m_tready,
    output logic          m_tlast,
    output logic          busy,
    output logic          overflow,
    input  logic          clr_ovf
);
    localparam logic [0:0] C_IDLE = 1'b0;
    localparam logic [0:0] C_RUN  = 1'b1;
    localparam logic [0:0] O_IDLE = 1'b0;
    localparam logic [0:0] O_SEND = 1'b1;
    localparam logic [3:0] OFS    = 4'(CAP_OFS);
    logic [0:0]    c_state_q, c_state_d, o_state_q, o_state_d;
    logic          wptr_q, wptr_d, rptr_q, rptr_d, ovf_q, ovf_d;
    logic [3:0]    cnt_q, cnt_d, idx_q, idx_d;
    logic [1:0]    full_q, full_d;
    logic [3:0]    blen_q [2];
    logic [3:0]    blen_d [2];
    logic [DW-1:0] bank_q [2][N];
    logic [DW-1:0] z_w [N];
    logic [3:0]    wlen, rlen, len_c, lane;
    logic          c_run, cap_en, cap_last, send, hs, beat_last, free, wr_empty, start_v, accept, drop;
    assign z_w       = '{z0, z1, z2, z3, z4, z5, z6, z7};
    assign wlen      = blen_q[wptr_q];
    assign rlen      = blen_q[rptr_q];
    assign len_c     = (len > 4'd8) ? 4'd8 : len;
    assign lane      = cnt_q - OFS;
    assign c_run     = c_state_q == C_RUN;
    assign cap_en    = c_run && cnt_q >= OFS && lane < wlen;
    assign cap_last  = c_run && cnt_q == OFS + wlen - 4'd1;
    assign send      = o_state_q == O_SEND;
    assign hs        = send && m_tready;
    assign beat_last = idx_q == rlen - 4'd1;
    assign free      = hs && beat_last;
    // a bank drained on this edge is already free for a new capture
    assign wr_empty  = !full_q[wptr_q] || (free && rptr_q == wptr_q);
    assign start_v   = start && len != 4'd0;
    assign accept    = start_v && !c_run && wr_empty;
    assign drop      = start_v && !accept;
    always_comb begin
        c_state_d = accept ? C_RUN : cap_last ? C_IDLE : c_state_q;
        cnt_d     = accept ? 4'd1 : c_run ? cnt_q + 4'd1 : cnt_q;
        wptr_d    = cap_last ? ~wptr_q : wptr_q;
        rptr_d    = free ? ~rptr_q : rptr_q;
        full_d    = full_q;
        blen_d    = blen_q;
        if (cap_last) full_d[wptr_q] = 1'b1;
        if (free) full_d[rptr_q] = 1'b0;
        if (accept) blen_d[wptr_q] = len_c;
        o_state_d = send ? (free ? (full_q[~rptr_q] ? O_SEND : O_IDLE) : O_SEND)
                         : (full_q[rptr_q] ? O_SEND : O_IDLE);
        idx_d     = (!send || free) ? 4'd0 : hs ? idx_q + 4'd1 : idx_q;
        ovf_d     = drop ? 1'b1 : clr_ovf ? 1'b0 : ovf_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_state_q <= C_IDLE;
            o_state_q <= O_IDLE;
            wptr_q    <= 1'b0;
            rptr_q    <= 1'b0;
            ovf_q     <= 1'b0;
            cnt_q     <= 4'd0;
            idx_q     <= 4'd0;
            full_q    <= 2'b00;
            blen_q    <= '{4'd0, 4'd0};
        end else begin
            c_state_q <= c_state_d;
            o_state_q <= o_state_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            ovf_q     <= ovf_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            full_q    <= full_d;
            blen_q    <= blen_d;
        end
    end
    always_ff @(posedge clk) begin
        if (cap_en) bank_q[wptr_q][lane[2:0]] <= z_w[lane[2:0]];
    end
    assign m_tvalid = send;
    assign m_tdata  = send ? bank_q[rptr_q][idx_q[2:0]] : '0;
    assign m_tlast  = send && beat_last;
    assign busy     = c_run || |full_q;
    assign overflow = ovf_q;
endmodule

// File: tb/tb_matrix_dp_collector.sv
// tb_matrix_dp_collector: table-driven, directed and random checks against a queue-based model of the collector
module tb_matrix_dp_collector;
    localparam int OFS = 3;
    typedef struct {
        logic [15:0] d;
        logic        l;
        int          r;
    } word_t;
    typedef struct {
        logic [3:0] len;
        int         eb;
        int         el;
    } tv_t;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  len = 4'd0;
    logic        tready = 1'b0;
    logic        clr_ovf = 1'b0;
    logic [15:0] z_drv [8];
    logic [15:0] m_tdata;
    logic        m_tvalid, m_tlast, busy, overflow;
    logic [15:0] vec_vals [8];
    int          n_pass = 0, n_tot = 0, edge_n = 0, beats = 0, lasts = 0;
    word_t       mq[$];
    int          occ = 0, cap_end = 0;
    logic        ovf_exp = 1'b0;
    int          pend_edge [8];
    logic [15:0] pend_val [8];
    tv_t         tbl [11];

    matrix_dp_collector #(.N(8), .DW(16), .CAP_OFS(OFS)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .z0(z_drv[0]), .z1(z_drv[1]), .z2(z_drv[2]), .z3(z_drv[3]),
        .z4(z_drv[4]), .z5(z_drv[5]), .z6(z_drv[6]), .z7(z_drv[7]),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(tready), .m_tlast(m_tlast),
        .busy(busy), .overflow(overflow), .clr_ovf(clr_ovf)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        edge_n++;
    end

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (edge %0d)", nm, act, exp, edge_n);
    endfunction

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            mq.delete();
            occ = 0;
            cap_end = 0;
            ovf_exp = 1'b0;
            for (int k = 0; k < 8; k++) pend_edge[k] = -1;
            chk("rst_tvalid", m_tvalid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_overflow", overflow, 0);
            for (int k = 0; k < 8; k++) z_drv[k] = 16'($urandom);
        end else begin : mdl
            int nx, lc;
            bit exp_v, fr, dr;
            word_t w;
            nx = edge_n + 1;
            exp_v = mq.size() > 0 && edge_n >= mq[0].r;
            chk("tvalid", m_tvalid, exp_v);
            if (exp_v) begin
                chk("tdata", m_tdata, mq[0].d);
                chk("tlast", m_tlast, mq[0].l);
            end
            chk("overflow", overflow, ovf_exp);
            chk("busy", busy, occ > 0);
            if (m_tvalid && tready) begin
                beats++;
                if (m_tlast) lasts++;
            end
            fr = 0;
            dr = 0;
            if (exp_v && tready) begin
                fr = mq[0].l;
                void'(mq.pop_front());
            end
            if (fr) occ--;
            if (start && len != 4'd0) begin
                lc = (len > 4'd8) ? 8 : int'(len);
                if (nx <= cap_end || occ >= 2) dr = 1;
                else begin
                    for (int k = 0; k < lc; k++) begin
                        w.d = vec_vals[k];
                        w.l = (k == lc - 1);
                        w.r = nx + OFS + lc;
                        mq.push_back(w);
                        pend_edge[k] = nx + OFS + k;
                        pend_val[k] = vec_vals[k];
                    end
                    occ++;
                    cap_end = nx + OFS + lc - 1;
                end
            end
            ovf_exp = dr ? 1'b1 : clr_ovf ? 1'b0 : ovf_exp;
            for (int k = 0; k < 8; k++) z_drv[k] = (pend_edge[k] == nx) ? pend_val[k] : 16'($urandom);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_vals();
        for (int k = 0; k < 8; k++) vec_vals[k] = 16'($urandom);
    endtask

    task automatic pulse(input logic [3:0] l);
        len = l;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_drain(input int max);
        int c;
        c = 0;
        while ((busy || occ > 0) && c < max) begin
            tick();
            c++;
        end
        chk("drain_in_time", 32'(c < max), 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        for (int i = 0; i < 8; i++) tbl[i] = '{4'(i + 1), i + 1, 1};
        tbl[8]  = '{4'd0, 0, 0};
        tbl[9]  = '{4'd12, 8, 1};
        tbl[10] = '{4'd15, 8, 1};
        for (int k = 0; k < 8; k++) begin
            pend_edge[k] = -1;
            z_drv[k] = 16'd0;
            vec_vals[k] = 16'd0;
        end
        repeat (3) tick();
        chk("reset_tdata", m_tdata, 0);
        chk("reset_tlast", m_tlast, 0);
        chk("reset_tvalid", m_tvalid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_overflow", overflow, 0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 11; i++) begin
            tready = 1'b1;
            beats = 0;
            lasts = 0;
            rand_vals();
            pulse(tbl[i].len);
            repeat (24) tick();
            chk("tbl_beats", beats, tbl[i].eb);
            chk("tbl_lasts", lasts, tbl[i].el);
            chk("tbl_overflow", overflow, 0);
            chk("tbl_busy", busy, 0);
        end

        beats = 0;
        lasts = 0;
        tready = 1'b1;
        vec_vals[0] = 16'h1234;
        vec_vals[1] = 16'h5678;
        vec_vals[2] = 16'h9ABC;
        pulse(3);
        repeat (5) tick();
        chk("basic_not_yet_valid", m_tvalid, 0);
        tick();
        chk("basic_first_valid", m_tvalid, 1);
        chk("basic_first_word", m_tdata, 16'h1234);
        wait_drain(20);
        chk("basic_beats", beats, 3);
        chk("basic_lasts", lasts, 1);
        chk("basic_busy_low", busy, 0);

        beats = 0;
        lasts = 0;
        tready = 1'b0;
        pulse(3);
        c = 0;
        while (!m_tvalid && c < 20) begin
            tick();
            c++;
        end
        chk("bp_valid_seen", m_tvalid, 1);
        repeat (4) begin
            chk("bp_hold_word", m_tdata, 16'h1234);
            tick();
        end
        for (int i = 0; i < 10; i++) begin
            tready = (i % 2 == 0);
            tick();
        end
        tready = 1'b1;
        wait_drain(20);
        chk("bp_beats", beats, 3);
        chk("bp_lasts", lasts, 1);

        beats = 0;
        lasts = 0;
        tready = 1'b0;
        vec_vals[0] = 16'h0001;
        vec_vals[1] = 16'h0002;
        pulse(2);
        repeat (4) tick();
        for (int k = 0; k < 8; k++) vec_vals[k] = 16'h0100 + 16'(k);
        pulse(8);
        repeat (12) tick();
        chk("pp_overflow", overflow, 0);
        chk("pp_busy", busy, 1);
        tready = 1'b1;
        repeat (10) tick();
        chk("pp_beats", beats, 10);
        chk("pp_lasts", lasts, 2);
        chk("pp_busy_low", busy, 0);

        beats = 0;
        lasts = 0;
        tready = 1'b0;
        rand_vals();
        pulse(3);
        repeat (6) tick();
        rand_vals();
        pulse(4);
        repeat (8) tick();
        chk("ovf_before", overflow, 0);
        rand_vals();
        pulse(5);
        chk("ovf_full_banks", overflow, 1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("ovf_cleared", overflow, 0);
        tready = 1'b1;
        wait_drain(30);
        chk("ovf_beats", beats, 7);
        chk("ovf_lasts", lasts, 2);
        beats = 0;
        rand_vals();
        pulse(4);
        repeat (2) tick();
        pulse(2);
        chk("ovf_in_run", overflow, 1);
        clr_ovf = 1'b1;
        pulse(2);
        chk("ovf_set_wins", overflow, 1);
        tick();
        clr_ovf = 1'b0;
        chk("ovf_clr_run", overflow, 0);
        wait_drain(30);
        chk("ovf_run_beats", beats, 4);

        pulse(0);
        tick();
        chk("len0_busy", busy, 0);
        chk("len0_overflow", overflow, 0);
        chk("len0_tvalid", m_tvalid, 0);

        beats = 0;
        lasts = 0;
        tready = 1'b1;
        rand_vals();
        pulse(3);
        c = 0;
        while (beats < 2 && c < 30) begin
            tick();
            c++;
        end
        rst_n = 1'b0;
        #1;
        chk("midrst_tvalid", m_tvalid, 0);
        chk("midrst_busy", busy, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (10) tick();
        chk("midrst_beats", beats, 2);
        chk("midrst_lasts", lasts, 0);
        beats = 0;
        lasts = 0;
        rand_vals();
        pulse(3);
        wait_drain(20);
        chk("postrst_beats", beats, 3);
        chk("postrst_lasts", lasts, 1);

        for (int i = 0; i < 400; i++) begin
            rand_vals();
            len = 4'($urandom_range(0, 15));
            start = ($urandom_range(0, 5) == 0);
            tready = ($urandom_range(0, 3) != 0);
            clr_ovf = ($urandom_range(0, 15) == 0);
            tick();
        end
        start = 1'b0;
        tready = 1'b1;
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        wait_drain(60);
        chk("rand_overflow_clear", overflow, 0);
        chk("rand_tvalid_idle", m_tvalid, 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
